branch_predict_resolve: RTL
===========================

// Module: branch_predict_resolve
// PURPOSE
//  Fetch-side branch direction predictor plus EX-side resolution/redirect controller for the RV32I core.
//  Predicts conditional branches using a bimodal table of 2-bit counters (BHT), indexed by PC.
//  Consumes the resolved branch condition from EX, trains the BHT, and detects mispredictions.
//  On a mispredict it issues a registered redirect and flush, then masks the wrong-path shadow.
// PARAMETERS
//  IDX_W      6      BHT index width; the BHT has 2**IDX_W entries.
//  INIT_CNT   2'b01  Counter reset value (weakly not-taken).
//  FLUSH_CYC  2      Cycles after a redirect during which EX resolutions are ignored (1..3).
// PORTS
//  clk           in   1   core clock; all state updates on the rising edge
//  rst           in   1   asynchronous, active-high reset
//  f_valid       in   1   fetch slot valid
//  f_is_br       in   1   predecode: fetched instruction is a conditional branch
//  f_pc          in   32  fetch PC
//  f_br_target   in   32  predecoded branch target (PC + B-immediate)
//  f_pred_taken  out  1   predicted direction; carried down the pipe to EX
//  f_next_pc     out  32  predicted next PC
//  ex_valid      in   1   EX slot valid
//  ex_is_br      in   1   EX instruction is a conditional branch
//  ex_stall      in   1   EX is held this cycle
//  ex_pc         in   32  PC of the EX instruction
//  ex_target     in   32  branch target computed in EX
//  ex_pred_taken in   1   prediction carried from fetch
//  ex_br_out     in   1   resolved condition from the branch compare unit (1 = taken)
//  redirect      out  1   one-cycle pulse: load redirect_pc into the PC
//  redirect_pc   out  32  corrected PC; valid while redirect = 1
//  flush         out  1   one-cycle pulse, coincident with redirect: kill IF/ID
// BEHAVIOUR
//  Reset: every BHT entry = INIT_CNT; redirect = 0, flush = 0, redirect_pc = 0; FSM = RUN; shadow count = 0.
//  Index: idx(pc) = pc[IDX_W+1:2].
//  Prediction (combinational, same cycle):
//   - f_pred_taken = f_valid & f_is_br & bht[idx(f_pc)][1]
//   - f_next_pc    = f_pred_taken ? f_br_target : f_pc + 4 (modulo 2**32; 0xFFFFFFFC wraps to 0)
//  Resolve event: res = ex_valid & ex_is_br & ~ex_stall & (state == RUN).
//  Training, on res at the clock edge:
//   - ex_br_out = 1: bht[idx(ex_pc)] saturating +1 (stops at 11).
//   - ex_br_out = 0: bht[idx(ex_pc)] saturating -1 (stops at 00).
//  Same-cycle fetch read and EX write to one index: the read returns the old value; no bypass.
//  Mispredict: mis = res & (ex_pred_taken != ex_br_out).
//  On the edge where mis = 1:
//   - redirect = 1 and flush = 1 for exactly one cycle (latency 1 clk after resolve).
//   - redirect_pc = ex_br_out ? ex_target : ex_pc + 4.
//  FSM:
//   - RUN -> SHADOW on mis; shadow count loads FLUSH_CYC.
//   - SHADOW: count decrements each cycle; resolutions are ignored (no train, no redirect).
//   - SHADOW -> RUN when count reaches 1.
//   - ex_stall does not freeze the shadow count.
//  Not a branch (ex_is_br = 0) or ex_valid = 0: no BHT update, no redirect.
//  ex_stall = 1: the resolve is deferred until the stall drops; the table is trained exactly once.
//  Reset asserted mid-operation: redirect/flush drop immediately, the FSM returns to RUN, and the BHT is reinitialised.
// CONFIGURATION
//  BP_PERF_CNT_EN defined:
//   - Adds outputs perf_br_cnt[31:0] (+1 per res) and perf_mis_cnt[31:0] (+1 per mis).
//   - Both counters are 0 on reset and wrap at 2**32.
//  BP_PERF_CNT_EN undefined: these ports and registers do not exist; behaviour is otherwise identical.
// STRUCTURE
//  Package bp_pkg:
//   - enum logic [1:0] bht_cnt_e {SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11}
//   - enum logic bp_state_e {RUN, SHADOW}
//   - function sat_update(bht_cnt_e c, logic taken)
//   - localparam PC_STEP = 32'd4
//  Sub-module bht_array:
//   - 2**IDX_W x 2-bit storage, async-reset to INIT_CNT
//   - one combinational read port, one synchronous write port
//  The top level holds prediction muxing, mispredict detection, the FSM and the redirect registers.
// TESTING
//  1. Reset, then fetch a branch at PC 0x100 with target 0x180 -> f_pred_taken = 0, f_next_pc = 0x104.
//  2. Resolve PC 0x100 taken twice (pred 0) -> redirect to 0x180 each time;
//     bht[0] goes 01->10->11, and the next fetch at 0x100 predicts taken with f_next_pc = 0x180.
//  3. Predicted taken, ex_br_out = 0 at PC 0x200 -> 1 cycle later redirect = flush = 1 for one cycle,
//     redirect_pc = 0x204; a branch resolving in the next FLUSH_CYC cycles is ignored.
//  4. Counter at 11 resolved taken 3 times -> stays 11; counter at 00 resolved not-taken -> stays 00.
//  5. ex_stall held 3 cycles with a mispredicting branch -> no redirect during the stall; a single redirect
//     follows release; bht changes exactly once.
//  6. Assert rst during SHADOW with redirect high -> redirect/flush = 0 immediately, all entries read 01;
//     with BP_PERF_CNT_EN, both perf counters read 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the bimodal branch predictor / resolve controller.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

    typedef enum logic {
        RUN,
        SHADOW
    } bp_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic bht_cnt_e sat_update(bht_cnt_e c, logic taken);
        bht_cnt_e r;
        r = c;
        if (taken) begin
            if (c != ST) r = bht_cnt_e'(c + 2'd1);
        end else begin
            if (c != SNT) r = bht_cnt_e'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bht_array.sv
// Branch history table: 2**IDX_W saturating 2-bit counters, one async read port,
// one synchronous read-modify-write training port.
module bht_array
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W    = 6,
    parameter logic [1:0]  INIT_CNT = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_cnt_e         rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    bht_cnt_e mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= bht_cnt_e'(INIT_CNT);
            end
        end else if (wr_en) begin
            mem[wr_idx] <= sat_update(mem[wr_idx], wr_taken);
        end
    end

    // Read returns the pre-edge value even when the same entry is being trained.
    assign rd_cnt = mem[rd_idx];

endmodule

// File: rtl/branch_predict_resolve.sv
// Fetch-side bimodal direction predictor plus EX-side resolve/redirect controller.
// Optional performance counters are enabled with `define BP_PERF_CNT_EN.
module branch_predict_resolve
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W     = 6,
    parameter logic [1:0]  INIT_CNT  = 2'b01,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_valid,
    input  logic        f_is_br,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_br_target,
    output logic        f_pred_taken,
    output logic [31:0] f_next_pc,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic        ex_stall,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        ex_br_out,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0] perf_br_cnt,
    output logic [31:0] perf_mis_cnt
`endif
);

    bht_cnt_e    f_cnt;
    bp_state_e   state_q, state_d;
    logic [1:0]  shadow_q, shadow_d;
    logic        res, mis;
    logic [31:0] fix_pc;

    bht_array #(
        .IDX_W    (IDX_W),
        .INIT_CNT (INIT_CNT)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (f_pc[IDX_W+1:2]),
        .rd_cnt   (f_cnt),
        .wr_en    (res),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (ex_br_out)
    );

    assign f_pred_taken = f_valid & f_is_br & f_cnt[1];
    assign f_next_pc    = f_pred_taken ? f_br_target : f_pc + PC_STEP;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        res      = ex_valid & ex_is_br & ~ex_stall & (state_q == RUN);
        mis      = res & (ex_pred_taken != ex_br_out);
        fix_pc   = ex_br_out ? ex_target : ex_pc + PC_STEP;
        case (state_q)
            RUN: begin
                if (mis) begin
                    state_d  = SHADOW;
                    shadow_d = 2'(FLUSH_CYC);
                end
            end
            SHADOW: begin
                // Shadow length runs on wall-clock cycles; an EX stall does not extend it.
                if (shadow_q == 2'd1) begin
                    state_d  = RUN;
                    shadow_d = '0;
                end else begin
                    shadow_d = shadow_q - 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            shadow_q    <= '0;
            redirect    <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            redirect <= mis;
            flush    <= mis;
            if (mis) redirect_pc <= fix_pc;
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_br_cnt  <= '0;
            perf_mis_cnt <= '0;
        end else begin
            if (res) perf_br_cnt  <= perf_br_cnt + 32'd1;
            if (mis) perf_mis_cnt <= perf_mis_cnt + 32'd1;
        end
    end
`endif

endmodule
